// File: rtl/multiply_pipe.sv
// ---------------------------------------------------------------------------
// multiply_pipe
// Fully pipelined signed fixed-point multiplier. Operands and result are in
// Q1.(WIDTH-1) format, so they cover [-1, 1). It accepts one sample per clock
// and has no backpressure. The latency is STAGES clocks. Rounding and
// saturation can be selected with parameters.
//
// Parameters:
//   WIDTH    - operand/result width (4..32)
//   MWIDTH   - width of the metadata carried alongside each sample
//   STAGES   - total latency in clocks (>= 3); extra stages are output delay
//   ROUND    - 1 = round half up, 0 = truncate (floor)
//   SATURATE - 1 = clamp overflow to max positive, 0 = wrap
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   x, y        - signed multiplicand / multiplier
//   in_nd       - input sample valid
//   in_m        - metadata travelling with the sample
//   clear_error - synchronous clear of error and ovf_count
//   z           - signed product
//   out_nd      - output sample valid
//   out_m       - metadata aligned with z
//   ovf         - one-cycle pulse with an out_nd sample that overflowed
//   error       - sticky overflow flag
//   ovf_count   - saturating count of overflowed samples
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module multiply_pipe #(
    parameter int WIDTH    = 16,
    parameter int MWIDTH   = 1,
    parameter int STAGES   = 3,
    parameter int ROUND    = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic              in_nd,
    input  logic [MWIDTH-1:0] in_m,
    input  logic              clear_error,
    output logic [WIDTH-1:0]  z,
    output logic              out_nd,
    output logic [MWIDTH-1:0] out_m,
    output logic              ovf,
    output logic              error,
    output logic [15:0]       ovf_count
);

    localparam int Extra = STAGES - 3;

    // Half an output LSB. Adding it before the shift turns floor into
    // round-half-up.
    localparam logic signed [2*WIDTH-1:0] RoundConst = (ROUND != 0) ?
        {{(WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}} : '0;

    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1: input registers
    logic signed [WIDTH-1:0]   x_q, y_q;
    logic                      nd1_q;
    logic [MWIDTH-1:0]         m1_q;

    // Stage 2: full-width product
    logic signed [2*WIDTH-1:0] prod_d, prod_q;
    logic                      nd2_q;
    logic [MWIDTH-1:0]         m2_q;

    // Stage 3: scaled, rounded and saturated result
    logic signed [2*WIDTH-1:0] roundSum;
    logic [WIDTH-1:0]          scaled;
    logic                      overflow;
    logic                      unusedLsbs;
    logic [WIDTH-1:0]          z3_d, z3_q;
    logic                      ovf3_d, ovf3_q;
    logic                      nd3_q;
    logic [MWIDTH-1:0]         m3_q;

    // Pipeline tail, after the optional delay line
    logic [WIDTH-1:0]          zOut;
    logic                      ndOut;
    logic                      ovfOut;
    logic [MWIDTH-1:0]         mOut;

    // Error tracking
    logic                      error_d, error_q;
    logic [15:0]               ovfCount_d, ovfCount_q;

    // Both operands are sign-extended to the full product width first, so
    // the product stays exact in 2*WIDTH bits.
    always_comb begin
        prod_d = $signed((2*WIDTH)'(x_q)) * $signed((2*WIDTH)'(y_q));
    end

    // Scaling keeps bits [2W-2 : W-1] of the rounded sum. This is the same
    // as an arithmetic shift right by W-1 followed by truncation to W bits.
    // The only product that does not fit is (-1)*(-1) = +1.0. In that case
    // the kept MSB differs from the sign of the full sum.
    always_comb begin
        roundSum   = prod_q + RoundConst;
        scaled     = roundSum[2*WIDTH-2:WIDTH-1];
        unusedLsbs = ^roundSum[WIDTH-2:0];
        overflow   = scaled[WIDTH-1] != roundSum[2*WIDTH-1];
        z3_d       = scaled;
        if (overflow) begin
            z3_d = (SATURATE != 0) ? MaxPos : MinNeg;
        end
        ovf3_d     = overflow & nd2_q;
    end

    // Main three-stage pipeline. The data, valid, metadata and overflow bits
    // all advance together every clock. There is no stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            nd1_q  <= 1'b0;
            m1_q   <= '0;
            prod_q <= '0;
            nd2_q  <= 1'b0;
            m2_q   <= '0;
            z3_q   <= '0;
            ovf3_q <= 1'b0;
            nd3_q  <= 1'b0;
            m3_q   <= '0;
        end else begin
            x_q    <= x;
            y_q    <= y;
            nd1_q  <= in_nd;
            m1_q   <= in_m;
            prod_q <= prod_d;
            nd2_q  <= nd1_q;
            m2_q   <= m1_q;
            z3_q   <= z3_d;
            ovf3_q <= ovf3_d;
            nd3_q  <= nd2_q;
            m3_q   <= m2_q;
        end
    end

    // Extra latency beyond three stages is a plain shift register on every
    // field. It is reset so that no stale sample can emerge after reset.
    generate
        if (Extra == 0) begin : g_noDelay
            assign zOut   = z3_q;
            assign ndOut  = nd3_q;
            assign ovfOut = ovf3_q;
            assign mOut   = m3_q;
        end else begin : g_delay
            logic [WIDTH-1:0]  zDly_q   [Extra];
            logic              ndDly_q  [Extra];
            logic              ovfDly_q [Extra];
            logic [MWIDTH-1:0] mDly_q   [Extra];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < Extra; i++) begin
                        zDly_q[i]   <= '0;
                        ndDly_q[i]  <= 1'b0;
                        ovfDly_q[i] <= 1'b0;
                        mDly_q[i]   <= '0;
                    end
                end else begin
                    zDly_q[0]   <= z3_q;
                    ndDly_q[0]  <= nd3_q;
                    ovfDly_q[0] <= ovf3_q;
                    mDly_q[0]   <= m3_q;
                    for (int i = 1; i < Extra; i++) begin
                        zDly_q[i]   <= zDly_q[i-1];
                        ndDly_q[i]  <= ndDly_q[i-1];
                        ovfDly_q[i] <= ovfDly_q[i-1];
                        mDly_q[i]   <= mDly_q[i-1];
                    end
                end
            end

            assign zOut   = zDly_q[Extra-1];
            assign ndOut  = ndDly_q[Extra-1];
            assign ovfOut = ovfDly_q[Extra-1];
            assign mOut   = mDly_q[Extra-1];
        end
    endgenerate

    assign z      = zOut;
    assign out_nd = ndOut;
    assign out_m  = mOut;
    assign ovf    = ovfOut & ndOut;

    // The sticky flag and the counter react to the ovf pulse on the next
    // edge. When clear_error and ovf coincide, the new overflow is kept.
    // So error stays set and the counter restarts at one.
    always_comb begin
        error_d = error_q;
        if (clear_error) begin
            error_d = 1'b0;
        end
        if (ovf) begin
            error_d = 1'b1;
        end

        ovfCount_d = ovfCount_q;
        if (clear_error) begin
            ovfCount_d = ovf ? 16'd1 : 16'd0;
        end else if (ovf && (ovfCount_q != 16'hFFFF)) begin
            ovfCount_d = ovfCount_q + 16'd1;
        end
    end

    // Error state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q    <= 1'b0;
            ovfCount_q <= '0;
        end else begin
            error_q    <= error_d;
            ovfCount_q <= ovfCount_d;
        end
    end

    assign error     = error_q;
    assign ovf_count = ovfCount_q;

endmodule

// File: tb/tb_multiply_pipe.sv
// ---------------------------------------------------------------------------
// tb_multiply_pipe
// Self-checking bench for multiply_pipe. Two instances share the same
// stimulus:
//   dutA: STAGES=5, ROUND=1, SATURATE=1
//   dutB: STAGES=3, ROUND=0, SATURATE=0
// The expected result of each valid input is queued when the input is driven.
// It is popped when the instance raises out_nd. The error flag and ovf_count
// are modelled cycle by cycle from the expected overflow pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_multiply_pipe;

    typedef struct {
        logic [15:0] z;
        logic [7:0]  m;
        logic        ovf;
        int          outCyc;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        in_nd = 1'b0;
    logic [7:0]  in_m = '0;
    logic        clear_error = 1'b0;

    logic [15:0] zA, zB;
    logic        ndA, ndB;
    logic [7:0]  mA, mB;
    logic        ovfA, ovfB;
    logic        errorA, errorB;
    logic [15:0] cntA, cntB;

    expT         qA[$];
    expT         qB[$];
    int          cyc = 0;
    int          compCount = 0;
    int          errCount = 0;
    int          inCount = 0;
    int          outCntA = 0;
    int          outCntB = 0;
    logic        errExpA = 1'b0, errExpB = 1'b0;
    logic [15:0] cntExpA = '0, cntExpB = '0;

    multiply_pipe #(.WIDTH(16), .MWIDTH(8), .STAGES(5), .ROUND(1), .SATURATE(1)) dutA (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_nd(in_nd), .in_m(in_m),
        .clear_error(clear_error), .z(zA), .out_nd(ndA), .out_m(mA),
        .ovf(ovfA), .error(errorA), .ovf_count(cntA)
    );

    multiply_pipe #(.WIDTH(16), .MWIDTH(8), .STAGES(3), .ROUND(0), .SATURATE(0)) dutB (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_nd(in_nd), .in_m(in_m),
        .clear_error(clear_error), .z(zB), .out_nd(ndB), .out_m(mB),
        .ovf(ovfB), .error(errorB), .ovf_count(cntB)
    );

    always #5 clk = ~clk;

    // Count edges so each expected sample carries the cycle it must appear in
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic done in plain integers: exact product, optional
    // half-LSB, arithmetic shift, then the overflow policy. Returns {ovf, z}.
    function automatic logic [16:0] refMul(input logic [15:0] a, input logic [15:0] b,
                                           input bit rnd, input bit sat);
        longint p;
        longint r;
        logic [15:0] zz;
        logic o;
        p = longint'($signed(a)) * longint'($signed(b));
        if (rnd) p = p + 64'sd16384;
        r = p >>> 15;
        o = (r > 64'sd32767);
        if (o) zz = sat ? 16'h7FFF : 16'h8000;
        else   zz = r[15:0];
        return {o, zz};
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs (called at posedge+2). Queue the expected
    // outputs of both instances if the sample is valid, then advance a cycle.
    task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv,
                                 input logic nd, input logic [7:0] mv, input logic clr,
                                 input logic [16:0] expA, input logic [16:0] expB);
        expT e;
        x = xv;
        y = yv;
        in_nd = nd;
        in_m = mv;
        clear_error = clr;
        if (nd) begin
            e.z = expA[15:0]; e.m = mv; e.ovf = expA[16]; e.outCyc = cyc + 5;
            qA.push_back(e);
            e.z = expB[15:0]; e.m = mv; e.ovf = expB[16]; e.outCyc = cyc + 3;
            qB.push_back(e);
            inCount++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic sendSample(input logic [15:0] xv, input logic [15:0] yv,
                              input logic nd, input logic [7:0] mv, input logic clr);
        applyStimulus(xv, yv, nd, mv, clr, refMul(xv, yv, 1'b1, 1'b1), refMul(xv, yv, 1'b0, 1'b0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sendSample(16'($urandom), 16'($urandom), 1'b0, 8'($urandom), 1'b0);
    endtask

    // Wait a bounded number of cycles for both queues to empty
    task automatic drainQueues;
        for (int i = 0; i < 20 && (qA.size() != 0 || qB.size() != 0); i++) idle(1);
        checkOutput("A.drain", 32'(qA.size()), 0);
        checkOutput("B.drain", 32'(qB.size()), 0);
    endtask

    // Monitor for dutA: reset values, scoreboard pop and error/count model
    always @(negedge clk) begin : monA
        expT e;
        logic eOvf;
        if (!rst_n) begin
            checkOutput("A.rst.z", 32'(zA), 0);
            checkOutput("A.rst.nd", 32'(ndA), 0);
            checkOutput("A.rst.m", 32'(mA), 0);
            checkOutput("A.rst.ovf", 32'(ovfA), 0);
            checkOutput("A.rst.error", 32'(errorA), 0);
            checkOutput("A.rst.count", 32'(cntA), 0);
            errExpA = 1'b0;
            cntExpA = '0;
        end else begin
            eOvf = 1'b0;
            checkOutput("A.error", 32'(errorA), 32'(errExpA));
            checkOutput("A.count", 32'(cntA), 32'(cntExpA));
            if (ndA) begin
                outCntA++;
                if (qA.size() == 0) begin
                    checkOutput("A.stray_nd", 32'(ndA), 0);
                end else begin
                    e = qA.pop_front();
                    checkOutput("A.z", 32'(zA), 32'(e.z));
                    checkOutput("A.m", 32'(mA), 32'(e.m));
                    checkOutput("A.ovf", 32'(ovfA), 32'(e.ovf));
                    checkOutput("A.latency", 32'(cyc), 32'(e.outCyc));
                    eOvf = e.ovf;
                end
            end else begin
                checkOutput("A.ovf_idle", 32'(ovfA), 0);
            end
            if (eOvf) errExpA = 1'b1;
            else if (clear_error) errExpA = 1'b0;
            if (clear_error) cntExpA = eOvf ? 16'd1 : 16'd0;
            else if (eOvf && cntExpA != 16'hFFFF) cntExpA = cntExpA + 16'd1;
        end
    end

    // Monitor for dutB, same structure
    always @(negedge clk) begin : monB
        expT e;
        logic eOvf;
        if (!rst_n) begin
            checkOutput("B.rst.z", 32'(zB), 0);
            checkOutput("B.rst.nd", 32'(ndB), 0);
            checkOutput("B.rst.m", 32'(mB), 0);
            checkOutput("B.rst.ovf", 32'(ovfB), 0);
            checkOutput("B.rst.error", 32'(errorB), 0);
            checkOutput("B.rst.count", 32'(cntB), 0);
            errExpB = 1'b0;
            cntExpB = '0;
        end else begin
            eOvf = 1'b0;
            checkOutput("B.error", 32'(errorB), 32'(errExpB));
            checkOutput("B.count", 32'(cntB), 32'(cntExpB));
            if (ndB) begin
                outCntB++;
                if (qB.size() == 0) begin
                    checkOutput("B.stray_nd", 32'(ndB), 0);
                end else begin
                    e = qB.pop_front();
                    checkOutput("B.z", 32'(zB), 32'(e.z));
                    checkOutput("B.m", 32'(mB), 32'(e.m));
                    checkOutput("B.ovf", 32'(ovfB), 32'(e.ovf));
                    checkOutput("B.latency", 32'(cyc), 32'(e.outCyc));
                    eOvf = e.ovf;
                end
            end else begin
                checkOutput("B.ovf_idle", 32'(ovfB), 0);
            end
            if (eOvf) errExpB = 1'b1;
            else if (clear_error) errExpB = 1'b0;
            if (clear_error) cntExpB = eOvf ? 16'd1 : 16'd0;
            else if (eOvf && cntExpB != 16'hFFFF) cntExpB = cntExpB + 16'd1;
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed vectors with hand-computed results:
    // A = round/saturate, B = truncate/wrap
    logic [15:0] dirX  [6] = '{16'h4000, 16'h0001, 16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF};
    logic [15:0] dirY  [6] = '{16'h4000, 16'h4000, 16'h4000, 16'h8000, 16'h7FFF, 16'h7FFF};
    logic [15:0] dirZa [6] = '{16'h2000, 16'h0001, 16'h0000, 16'h7FFF, 16'h8001, 16'h7FFE};
    logic [15:0] dirZb [6] = '{16'h2000, 16'h0000, 16'hFFFF, 16'h8000, 16'h8001, 16'h7FFE};
    logic        dirO  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [15:0] rx, ry;
        // Hold reset for a few cycles, then release between edges
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // First sample on its own, so an early or repeated out_nd shows up
        applyStimulus(dirX[0], dirY[0], 1'b1, 8'd0, 1'b0, {dirO[0], dirZa[0]}, {dirO[0], dirZb[0]});
        idle(7);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(dirX[i], dirY[i], 1'b1, 8'(i), 1'b0, {dirO[i], dirZa[i]}, {dirO[i], dirZb[i]});
        end
        drainQueues();
        idle(2);
        // A clear pulse alone drops the sticky flag and the counter
        sendSample(16'h0, 16'h0, 1'b0, 8'h0, 1'b1);
        idle(3);

        // Random stream with gaps; metadata is the sample index
        inCount = 0;
        outCntA = 0;
        outCntB = 0;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) begin
                rx = 16'h8000;
                ry = 16'h8000;
            end else begin
                rx = 16'($urandom);
                ry = 16'($urandom);
            end
            sendSample(rx, ry, 1'b1, 8'(i), 1'b0);
        end
        drainQueues();
        checkOutput("A.nd_count", 32'(outCntA), 32'(inCount));
        checkOutput("B.nd_count", 32'(outCntB), 32'(inCount));

        // Reset mid-stream with three samples in flight
        for (int i = 0; i < 3; i++) sendSample(16'h4000, 16'h2000, 1'b1, 8'(200 + i), 1'b0);
        rst_n = 1'b0;
        qA.delete();
        qB.delete();
        #1;
        checkOutput("A.async_rst.z", 32'(zA), 0);
        checkOutput("A.async_rst.nd", 32'(ndA), 0);
        checkOutput("A.async_rst.error", 32'(errorA), 0);
        checkOutput("B.async_rst.z", 32'(zB), 0);
        checkOutput("B.async_rst.nd", 32'(ndB), 0);
        checkOutput("B.async_rst.count", 32'(cntB), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(8);
        sendSample(16'h6000, 16'h4000, 1'b1, 8'd77, 1'b0);
        drainQueues();

        // Counter saturation: a long run of overflowing samples. Near the end,
        // clear_error coincides with an ovf pulse.
        for (int i = 0; i < 70000; i++) begin
            sendSample(16'h8000, 16'h8000, 1'b1, 8'(i), (i == 69990) ? 1'b1 : 1'b0);
        end
        drainQueues();
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
